// File: rtl/anim_frame_seq.sv
// anim_frame_seq: steps a frame index 0..LAST_FRAME at a programmable rate in one-shot, loop or ping-pong mode
module anim_frame_seq #(
    parameter int FRAME_W    = 5,
    parameter int LAST_FRAME = 16,
    parameter int DIV_W      = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   period,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick,
    output logic               busy,
    output logic               done
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN_FWD = 2'd1;
    localparam logic [1:0] RUN_REV = 2'd2;
    localparam logic [FRAME_W-1:0] LAST = FRAME_W'(LAST_FRAME);

    logic [1:0]         state_q, state_d, mode_q, mode_d;
    logic [DIV_W-1:0]   per_q, per_d, cnt_q, cnt_d, last_cnt;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               tick_q, tick_d, done_q, done_d, busy_q, busy_d;

    // Next-state: abort beats start, start beats pause, pause beats advance
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        per_d    = per_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        last_cnt = (per_q == '0) ? '0 : per_q - 1'b1;
        if (abort) begin
            state_d = IDLE;
            frame_d = '0;
            cnt_d   = '0;
        end else if (start) begin
            mode_d  = mode;
            per_d   = period;
            state_d = RUN_FWD;
            frame_d = '0;
            cnt_d   = '0;
        end else if (state_q != IDLE && !pause) begin
            if (cnt_q != last_cnt) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (state_q == RUN_REV) begin
                    frame_d = (frame_q == '0) ? FRAME_W'(1) : frame_q - 1'b1;
                    state_d = (frame_q == '0) ? RUN_FWD : RUN_REV;
                end else if (frame_q != LAST) begin
                    frame_d = frame_q + 1'b1;
                end else if (mode_q == 2'b01) begin
                    frame_d = '0;
                end else if (mode_q == 2'b10) begin
                    frame_d = LAST - 1'b1;
                    state_d = RUN_REV;
                end else begin
                    frame_d = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
        busy_d = state_d != IDLE;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            per_q   <= DIV_W'(1);
            cnt_q   <= '0;
            frame_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign frame      = frame_q;
    assign frame_tick = tick_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
